// File: rtl/if_stage_if.sv
// Instruction-memory bus between the fetch stage and the instruction memory.
//   imem_req   : fetch stage requests an instruction at imem_addr
//   imem_addr  : fetch address, held stable until imem_ready
//   imem_ready : response valid (same cycle as the request or later)
//   imem_rdata : fetched instruction, valid with imem_ready
// master = fetch stage, slave = memory.
interface if_stage_if #(
  parameter int BUS_WIDTH   = 64,
  parameter int INSTR_WIDTH = 32
);
  logic                   imem_req;
  logic [BUS_WIDTH-1:0]   imem_addr;
  logic                   imem_ready;
  logic [INSTR_WIDTH-1:0] imem_rdata;

  modport master (output imem_req, imem_addr, input  imem_ready, imem_rdata);
  modport slave  (input  imem_req, imem_addr, output imem_ready, imem_rdata);
endinterface

// File: rtl/if_stage.sv
// Instruction fetch stage with IF/ID pipeline register.
// Fetches from fpc each cycle, with a one-entry skid buffer to absorb a
// response that lands while decode is stalled, and a drain state that
// swallows an outstanding response after a redirect.
// Ports:
//   clk, rst          : clock, synchronous active-high reset
//   stall             : hazard unit holds the IF/ID register
//   imm_pc            : redirect request from decode
//   next_imm_pc       : redirect target
//   imem              : instruction memory bus (master side)
//   pc, instr, valid  : IF/ID register outputs to decode
module if_stage #(
  parameter int                   BUS_WIDTH   = 64,
  parameter int                   INSTR_WIDTH = 32,
  parameter logic [BUS_WIDTH-1:0] RESET_PC    = '0
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   stall,
  input  logic                   imm_pc,
  input  logic [BUS_WIDTH-1:0]   next_imm_pc,
  if_stage_if.master             imem,
  output logic [BUS_WIDTH-1:0]   pc,
  output logic [INSTR_WIDTH-1:0] instr,
  output logic                   valid
);

  localparam logic [1:0] FETCH = 2'd0;
  localparam logic [1:0] HOLD  = 2'd1;
  localparam logic [1:0] DRAIN = 2'd2;

  localparam logic [INSTR_WIDTH-1:0] NOP  = INSTR_WIDTH'(32'h0000_0013);
  localparam logic [BUS_WIDTH-1:0]   STEP = BUS_WIDTH'(4);

  typedef struct packed {
    logic [BUS_WIDTH-1:0]   pc;
    logic [INSTR_WIDTH-1:0] instr;
  } slot_t;

  localparam slot_t BUBBLE = '{pc: '0, instr: NOP};

  logic [1:0]           state;
  logic [BUS_WIDTH-1:0] fpc;
  logic [BUS_WIDTH-1:0] pend_pc;
  slot_t                skid;
  slot_t                out_q;
  logic                 valid_q;
  logic                 redirect;

  // A stalled decode cannot be trusted to have resolved its branch.
  assign redirect = imm_pc & ~stall;

  // Address comes straight from fpc, so it is stable while a request waits.
  assign imem.imem_addr = fpc;
  assign imem.imem_req  = (state != HOLD);

  assign pc    = out_q.pc;
  assign instr = out_q.instr;
  assign valid = valid_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      fpc     <= RESET_PC;
      state   <= FETCH;
      out_q   <= BUBBLE;
      valid_q <= 1'b0;
      skid    <= '0;
      pend_pc <= '0;
    end else begin
      case (state)
        FETCH: begin
          if (redirect) begin
            out_q   <= BUBBLE;
            valid_q <= 1'b0;
            if (imem.imem_ready) begin
              fpc <= next_imm_pc;
            end else begin
              // Request still in flight: keep the address, eat the reply later.
              pend_pc <= next_imm_pc;
              state   <= DRAIN;
            end
          end else if (imem.imem_ready) begin
            if (stall) begin
              skid  <= '{pc: fpc, instr: imem.imem_rdata};
              state <= HOLD;
            end else begin
              out_q   <= '{pc: fpc, instr: imem.imem_rdata};
              valid_q <= 1'b1;
              fpc     <= fpc + STEP;
            end
          end else if (!stall) begin
            out_q   <= BUBBLE;
            valid_q <= 1'b0;
          end
        end
        HOLD: begin
          if (redirect) begin
            out_q   <= BUBBLE;
            valid_q <= 1'b0;
            fpc     <= next_imm_pc;
            state   <= FETCH;
          end else if (!stall) begin
            out_q   <= skid;
            valid_q <= 1'b1;
            fpc     <= skid.pc + STEP;
            state   <= FETCH;
          end
        end
        DRAIN: begin
          if (!stall) begin
            out_q   <= BUBBLE;
            valid_q <= 1'b0;
          end
          if (redirect) pend_pc <= next_imm_pc;
          if (imem.imem_ready) begin
            // A redirect in the same cycle as the stale reply wins.
            fpc   <= redirect ? next_imm_pc : pend_pc;
            state <= FETCH;
          end
        end
        default: state <= FETCH;
      endcase
    end
  end

endmodule
